// File: rtl/sw_cmd_if.sv
// Button, stopwatch-status and command/lap signals between the stopwatch
// front end (sw_cmd_ctrl) and the stopwatch time manager.
//
// Handshake: the controller drives cmd (non-zero) and raises busy in the same
// cycle. Both stay constant until state_in shows the state the command asks
// for. cmd and busy then drop together on the next clock edge. If that state
// does not appear within the timeout, cmd and busy drop and err pulses for one
// cycle. A new command is never issued while busy is high.
interface sw_cmd_if;
  logic       btn_ss;
  logic       btn_clr;
  logic       btn_lap;
  logic [1:0] state_in;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic [1:0] cmd;
  logic       busy;
  logic       err;
  logic       lap_valid;
  logic [5:0] lap_min;
  logic [5:0] lap_sec;
  logic       fsm_state;  // debug view of the sequencer: 0 IDLE, 1 WAIT

  modport master (
    output btn_ss, btn_clr, btn_lap, state_in, min_in, sec_in,
    input  cmd, busy, err, lap_valid, lap_min, lap_sec, fsm_state
  );

  modport slave (
    input  btn_ss, btn_clr, btn_lap, state_in, min_in, sec_in,
    output cmd, busy, err, lap_valid, lap_min, lap_sec, fsm_state
  );
endinterface

// File: rtl/sw_cmd_ctrl.sv
// Stopwatch command sequencer: debounces three push buttons, turns presses
// into start/stop/stop-reset commands chosen from the stopwatch state, holds
// each command until the stopwatch confirms it (or times out), and keeps a
// lap snapshot of min/sec.
module sw_cmd_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input logic     clk,
  input logic     rst,
  sw_cmd_if.slave bus
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);
  localparam logic [3:0] ACK_MAX = 4'(ACK_TIMEOUT);

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_STOP  = 2'b10;
  localparam logic [1:0] ST_SRST  = 2'b11;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_SRST  = 2'd3;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Button index: 0 start/stop, 1 clear, 2 lap.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [3:0] deb_cnt [3];
  logic [2:0] deb;
  logic [2:0] deb_q;
  logic [2:0] press;

  state_t     state;
  logic [1:0] cmd_q;
  logic       busy_q;
  logic       err_q;
  logic [3:0] tcnt;
  logic       ack;
  logic       lap_clear;

  logic       lap_valid_q;
  logic [5:0] lap_min_q;
  logic [5:0] lap_sec_q;

  assign raw = {bus.btn_lap, bus.btn_clr, bus.btn_ss};

  // Two-flop synchronisers, saturating debounce counters and edge registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (!sync2[i])
          deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DEB_MAX)
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
      end
    end
  end

  // Debounced level and single-cycle press pulse on its rising edge.
  always_comb begin
    deb   = '0;
    for (int i = 0; i < 3; i++) deb[i] = (deb_cnt[i] == DEB_MAX);
    press = deb & ~deb_q;
  end

  // Acknowledge: stopwatch state matches what the outstanding command asks for.
  always_comb begin
    ack = 1'b0;
    case (cmd_q)
      CMD_START: ack = (bus.state_in == ST_START);
      CMD_STOP:  ack = (bus.state_in == ST_STOP);
      CMD_SRST:  ack = (bus.state_in == ST_SRST) || (bus.state_in == ST_INIT);
      default:   ack = 1'b0;
    endcase
    lap_clear = (state == WAIT) && ack && (cmd_q == CMD_SRST);
  end

  // Command sequencer. A clear press takes the cycle even when the current
  // state makes it a no-op, so a simultaneous start/stop press is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cmd_q  <= CMD_NONE;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      tcnt   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (press[1]) begin
            if (bus.state_in == ST_START || bus.state_in == ST_STOP) begin
              cmd_q  <= CMD_SRST;
              busy_q <= 1'b1;
              tcnt   <= '0;
              state  <= WAIT;
            end
          end else if (press[0]) begin
            case (bus.state_in)
              ST_INIT, ST_STOP: begin
                cmd_q  <= CMD_START;
                busy_q <= 1'b1;
                tcnt   <= '0;
                state  <= WAIT;
              end
              ST_START: begin
                cmd_q  <= CMD_STOP;
                busy_q <= 1'b1;
                tcnt   <= '0;
                state  <= WAIT;
              end
              default: ;
            endcase
          end
        end
        WAIT: begin
          if (ack) begin
            cmd_q  <= CMD_NONE;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (tcnt + 4'd1 >= ACK_MAX) begin
            cmd_q  <= CMD_NONE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
            tcnt   <= ACK_MAX;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lap snapshot; a confirmed stop-reset wipes it and beats a same-cycle lap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_valid_q <= 1'b0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
    end else if (lap_clear) begin
      lap_valid_q <= 1'b0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
    end else if (press[2] && bus.state_in == ST_START) begin
      lap_valid_q <= 1'b1;
      lap_min_q   <= bus.min_in;
      lap_sec_q   <= bus.sec_in;
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.lap_min   = lap_min_q;
  assign bus.lap_sec   = lap_sec_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_sw_cmd_ctrl.sv
// Bench for sw_cmd_ctrl: directed vector table, hand-written reset sequence,
// then randomised buttons/state checked every cycle against a reference model.
module tb_sw_cmd_ctrl;

  localparam int DEB  = 4;
  localparam int ACK  = 4;
  localparam int HMAX = 4096;

  logic clk;
  logic rst;

  sw_cmd_if bus ();

  sw_cmd_ctrl #(.DEB_CYCLES(DEB), .ACK_TIMEOUT(ACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Raw button samples per edge since the last reset; the debounced level after
  // edge j is "the DEB samples taken 2..DEB+1 edges earlier were all high".
  logic hist [3][HMAX];
  int   cyc;

  logic [1:0] m_cmd;
  int         m_age;
  logic       m_err;
  logic       m_lv;
  logic [5:0] m_lmin;
  logic [5:0] m_lsec;

  function automatic logic deb_at(int b, int j);
    if (j - 1 - DEB < 0) return 1'b0;
    for (int i = j - 1 - DEB; i <= j - 2; i++)
      if (!hist[b][i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic pulse_at(int b, int j);
    return deb_at(b, j) && !deb_at(b, j - 1);
  endfunction

  function automatic logic acked(logic [1:0] c, logic [1:0] st);
    case (c)
      2'd1:    return st == 2'b01;
      2'd2:    return st == 2'b10;
      2'd3:    return (st == 2'b11) || (st == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    cyc    = 0;
    m_cmd  = 2'd0;
    m_age  = 0;
    m_err  = 1'b0;
    m_lv   = 1'b0;
    m_lmin = '0;
    m_lsec = '0;
  endtask

  // One clock edge k with state/min/sec sampled at that edge.
  task automatic model_step(int k, logic [1:0] st, logic [5:0] mn, logic [5:0] sc);
    logic p_ss, p_clr, p_lap, wipe;
    p_ss  = pulse_at(0, k - 1);
    p_clr = pulse_at(1, k - 1);
    p_lap = pulse_at(2, k - 1);
    wipe  = 1'b0;
    m_err = 1'b0;
    if (m_cmd != 2'd0) begin
      if (acked(m_cmd, st)) begin
        wipe  = (m_cmd == 2'd3);
        m_cmd = 2'd0;
      end else begin
        m_age++;
        if (m_age >= ACK) begin
          m_cmd = 2'd0;
          m_err = 1'b1;
        end
      end
    end else if (p_clr) begin
      if (st == 2'b01 || st == 2'b10) begin
        m_cmd = 2'd3;
        m_age = 0;
      end
    end else if (p_ss) begin
      m_age = 0;
      if (st == 2'b00 || st == 2'b10) m_cmd = 2'd1;
      else if (st == 2'b01)           m_cmd = 2'd2;
    end
    if (wipe) begin
      m_lv = 1'b0; m_lmin = '0; m_lsec = '0;
    end else if (p_lap && st == 2'b01) begin
      m_lv = 1'b1; m_lmin = mn; m_lsec = sc;
    end
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [16:0] dut_vec();
    return {bus.cmd, bus.busy, bus.err, bus.lap_valid, bus.lap_min, bus.lap_sec};
  endfunction

  function automatic logic [16:0] mk_exp(logic [1:0] c, logic b, logic e, logic lv,
                                         logic [5:0] lm, logic [5:0] ls);
    return {c, b, e, lv, lm, ls};
  endfunction

  task automatic chk(string name, logic [16:0] got, logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got cmd=%0d busy=%0d err=%0d lap_valid=%0d lap_min=%0d lap_sec=%0d, expected cmd=%0d busy=%0d err=%0d lap_valid=%0d lap_min=%0d lap_sec=%0d",
               name, got[16:15], got[14], got[13], got[12], got[11:6], got[5:0],
               exp[16:15], exp[14], exp[13], exp[12], exp[11:6], exp[5:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(logic ss, logic clr, logic lap, logic [1:0] st,
                       logic [5:0] mn, logic [5:0] sc);
    bus.btn_ss   = ss;
    bus.btn_clr  = clr;
    bus.btn_lap  = lap;
    bus.state_in = st;
    bus.min_in   = mn;
    bus.sec_in   = sc;
  endtask

  // Advance one edge; inputs are stable here, so they are what the edge samples.
  task automatic tick();
    logic [1:0] st;
    logic [5:0] mn, sc;
    if (cyc >= HMAX) begin
      errors++;
      $display("FAIL history: cycle budget %0d exceeded", HMAX);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "history overflow");
    end
    hist[0][cyc] = bus.btn_ss;
    hist[1][cyc] = bus.btn_clr;
    hist[2][cyc] = bus.btn_lap;
    st = bus.state_in;
    mn = bus.min_in;
    sc = bus.sec_in;
    @(posedge clk);
    model_step(cyc, st, mn, sc);
    cyc++;
    #1;
    chk("model", dut_vec(), mk_exp(m_cmd, m_cmd != 2'd0, m_err, m_lv, m_lmin, m_lsec));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        ss;
    logic        clr;
    logic        lap;
    logic [1:0]  st;
    logic [5:0]  mn;
    logic [5:0]  sc;
    int          n;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(string name, logic ss, logic clr, logic lap, logic [1:0] st,
                     logic [5:0] mn, logic [5:0] sc, int n, logic [16:0] exp);
    vec_t v;
    v.name = name; v.ss = ss; v.clr = clr; v.lap = lap; v.st = st;
    v.mn = mn; v.sc = sc; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  int hold [3];
  logic lvl [3];

  initial begin
    // Start/stop press from INIT, confirmed after two WAIT cycles.
    add("idle",         0, 0, 0, 2'b00, 0,  0,  1, mk_exp(0, 0, 0, 0, 0, 0));
    add("ss_debounce",  1, 0, 0, 2'b00, 0,  0,  6, mk_exp(0, 0, 0, 0, 0, 0));
    add("ss_start",     1, 0, 0, 2'b00, 0,  0,  1, mk_exp(1, 1, 0, 0, 0, 0));
    add("start_hold",   1, 0, 0, 2'b00, 0,  0,  2, mk_exp(1, 1, 0, 0, 0, 0));
    add("start_ack",    1, 0, 0, 2'b01, 0,  0,  1, mk_exp(0, 0, 0, 0, 0, 0));
    add("release",      0, 0, 0, 2'b01, 0,  0,  4, mk_exp(0, 0, 0, 0, 0, 0));
    // Three-cycle glitch is shorter than the debounce window.
    add("glitch",       1, 0, 0, 2'b01, 0,  0,  3, mk_exp(0, 0, 0, 0, 0, 0));
    add("glitch_quiet", 0, 0, 0, 2'b01, 0,  0,  5, mk_exp(0, 0, 0, 0, 0, 0));
    // Stop command never confirmed -> timeout.
    add("ss_stop",      1, 0, 0, 2'b01, 0,  0,  7, mk_exp(2, 1, 0, 0, 0, 0));
    add("stop_wait",    1, 0, 0, 2'b01, 0,  0,  3, mk_exp(2, 1, 0, 0, 0, 0));
    add("timeout",      1, 0, 0, 2'b01, 0,  0,  1, mk_exp(0, 0, 1, 0, 0, 0));
    add("err_pulse",    0, 0, 0, 2'b01, 0,  0,  1, mk_exp(0, 0, 0, 0, 0, 0));
    add("quiet",        0, 0, 0, 2'b01, 0,  0,  3, mk_exp(0, 0, 0, 0, 0, 0));
    // Lap capture in START, ignored in STOP.
    add("lap_deb",      0, 0, 1, 2'b01, 3,  42, 6, mk_exp(0, 0, 0, 0, 0, 0));
    add("lap_take",     0, 0, 1, 2'b01, 3,  42, 1, mk_exp(0, 0, 0, 1, 3, 42));
    add("lap_keep",     0, 0, 0, 2'b01, 7,  9,  4, mk_exp(0, 0, 0, 1, 3, 42));
    add("lap_in_stop",  0, 0, 1, 2'b10, 11, 5,  7, mk_exp(0, 0, 0, 1, 3, 42));
    add("lap_release",  0, 0, 0, 2'b10, 0,  0,  4, mk_exp(0, 0, 0, 1, 3, 42));
    // Simultaneous ss+clr in STOP: clear wins; confirm wipes the lap.
    add("clr_prio",     1, 1, 0, 2'b10, 0,  0,  7, mk_exp(3, 1, 0, 1, 3, 42));
    add("clr_ack",      1, 1, 0, 2'b11, 0,  0,  1, mk_exp(0, 0, 0, 0, 0, 0));
    add("clr_release",  0, 0, 0, 2'b11, 0,  0,  4, mk_exp(0, 0, 0, 0, 0, 0));
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), mk_exp(0, 0, 0, 0, 0, 0));
    rst = 1'b1;

    foreach (tbl[r]) begin
      drive(tbl[r].ss, tbl[r].clr, tbl[r].lap, tbl[r].st, tbl[r].mn, tbl[r].sc);
      for (int c = 0; c < tbl[r].n; c++) tick();
      chk(tbl[r].name, dut_vec(), tbl[r].exp);
    end

    // Reset in the middle of an outstanding start command.
    drive(1, 0, 0, 2'b00, 0, 0);
    repeat (7) tick();
    chk("pre_rst_cmd", dut_vec(), mk_exp(1, 1, 0, 0, 0, 0));
    tick();
    drive(0, 0, 0, 2'b00, 0, 0);
    rst = 1'b0;
    #1;
    chk("async_rst", dut_vec(), mk_exp(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("post_rst_idle", dut_vec(), mk_exp(0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 2'b00, 0, 0);
    repeat (7) tick();
    chk("fresh_cmd", dut_vec(), mk_exp(1, 1, 0, 0, 0, 0));
    drive(1, 0, 0, 2'b01, 0, 0);
    tick();
    chk("fresh_ack", dut_vec(), mk_exp(0, 0, 0, 0, 0, 0));

    // Randomised buttons, stopwatch state and time, checked every edge.
    for (int b = 0; b < 3; b++) begin
      hold[b] = 0;
      lvl[b]  = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = ($urandom_range(0, 2) == 0);
          hold[b] = $urandom_range(1, 12);
        end
        hold[b]--;
      end
      bus.btn_ss  = lvl[0];
      bus.btn_clr = lvl[1];
      bus.btn_lap = lvl[2];
      if ($urandom_range(0, 3) == 0) bus.state_in = 2'($urandom_range(0, 3));
      bus.min_in = 6'($urandom_range(0, 59));
      bus.sec_in = 6'($urandom_range(0, 59));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
